// File: rtl/neosd_pkg.sv
// Shared types and default constants for the NEOSD SD clock generator.
package neosd_pkg;

  localparam int NEOSD_DIV_W   = 8;
  localparam int NEOSD_NUM_REQ = 2;
  localparam int NEOSD_BURST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } neosd_clkgen_state_t;

endpackage

// File: rtl/neosd_clkgen_burst.sv
// Burst counter: keeps the SD clock running for a fixed number of rising edges.
// Only instantiated when NEOSD_CLKGEN_BURST_EN is defined.
module neosd_clkgen_burst
  import neosd_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [NEOSD_BURST_W-1:0] len_i,
  input  logic                     rise_strb_i,
  input  logic                     fall_set_i,
  output logic                     busy_o
);

  logic [NEOSD_BURST_W-1:0] cnt_q, cnt_d;
  logic                     busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (!busy_q) begin
      if (start_i && (len_i != '0)) begin
        cnt_d  = len_i;
        busy_d = 1'b1;
      end
    end else begin
      if (rise_strb_i) begin
        cnt_d = cnt_q - 1'b1;
      end
      // Drop busy on the same edge that raises fall_strb_o after the last rise,
      // so en_o is already low when the final low phase is evaluated.
      if (fall_set_i && (cnt_d == '0)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/neosd_clkgen.sv
// SD card clock generator: divided, glitch-free clock that always stops low.
// Optional burst mode is enabled by defining NEOSD_CLKGEN_BURST_EN.
module neosd_clkgen
  import neosd_pkg::*;
#(
  parameter int DIV_W   = NEOSD_DIV_W,
  parameter int NUM_REQ = NEOSD_NUM_REQ
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DIV_W-1:0]         div_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       stall_i,
  input  logic                     burst_start_i,
  input  logic [NEOSD_BURST_W-1:0] burst_len_i,
  output logic                     burst_busy_o,
  output logic                     en_o,
  output logic                     sd_clk_o,
  output logic                     rise_strb_o,
  output logic                     fall_strb_o,
  output logic                     running_o
);

  neosd_clkgen_state_t state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                sd_clk_q, sd_clk_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                burst_busy;
  logic                en;
  logic                half_done;

  assign en        = ((|req_i) & ~(|stall_i)) | burst_busy;
  assign half_done = (cnt_q == div_q);

  always_comb begin
    // NOTE: every output of this block gets a default first; a missing
    // assignment on any path would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sd_clk_d = sd_clk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        sd_clk_d = 1'b0;
        div_d    = div_i;
        if (en) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (half_done) begin
          cnt_d = '0;
          if (en) begin
            state_d  = ST_HIGH;
            sd_clk_d = 1'b1;
            rise_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        // en is ignored here so a high phase is never cut short.
        if (half_done) begin
          state_d  = ST_LOW;
          sd_clk_d = 1'b0;
          fall_d   = 1'b1;
          cnt_d    = '0;
          div_d    = div_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        sd_clk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      sd_clk_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sd_clk_q <= sd_clk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

`ifdef NEOSD_CLKGEN_BURST_EN
  neosd_clkgen_burst u_burst (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (burst_start_i),
    .len_i       (burst_len_i),
    .rise_strb_i (rise_q),
    .fall_set_i  (fall_d),
    .busy_o      (burst_busy)
  );
`else
  logic unused_burst;
  assign unused_burst = ^{burst_start_i, burst_len_i};
  assign burst_busy   = 1'b0;
`endif

  assign burst_busy_o = burst_busy;
  assign en_o         = en;
  assign sd_clk_o     = sd_clk_q;
  assign rise_strb_o  = rise_q;
  assign fall_strb_o  = fall_q;
  assign running_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neosd_clkgen.sv
// Directed self-checking bench for neosd_clkgen (burst checks need NEOSD_CLKGEN_BURST_EN).
module tb_neosd_clkgen;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] div_i = '0;
  logic [1:0] req_i = '0;
  logic [1:0] stall_i = '0;
  logic       burst_start_i = 1'b0;
  logic [7:0] burst_len_i = '0;
  logic       burst_busy_o, en_o, sd_clk_o, rise_strb_o, fall_strb_o, running_o;

  int checks = 0;
  int failures = 0;
  int strb_viol = 0;
  int rise_cnt = 0;

  neosd_clkgen dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .div_i         (div_i),
    .req_i         (req_i),
    .stall_i       (stall_i),
    .burst_start_i (burst_start_i),
    .burst_len_i   (burst_len_i),
    .burst_busy_o  (burst_busy_o),
    .en_o          (en_o),
    .sd_clk_o      (sd_clk_o),
    .rise_strb_o   (rise_strb_o),
    .fall_strb_o   (fall_strb_o),
    .running_o     (running_o)
  );

  always #5 clk_i = ~clk_i;

  // Strobe exclusivity and IDLE-quiet monitor, plus a running count of rises.
  always @(negedge clk_i) begin
    if (rise_strb_o && fall_strb_o) strb_viol++;
    if (!running_o && (rise_strb_o || fall_strb_o)) strb_viol++;
    if (rise_strb_o) rise_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!rise_strb_o && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (running_o && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (sd_clk_o == lvl && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n, h, l, r0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_sd_clk", sd_clk_o, 0);
    check("rst_rise", rise_strb_o, 0);
    check("rst_fall", fall_strb_o, 0);
    check("rst_running", running_o, 0);
    check("rst_busy", burst_busy_o, 0);
    check("rst_en", en_o, 0);
    rst_i = 1'b0;
    tick();

    // Divider 3: first rise after div+2, then 4 high / 4 low
    div_i = 8'd3;
    req_i = 2'b01;
    #1;
    check("div3_en", en_o, 1);
    wait_rise(n);
    check("div3_first_rise", n, 5);
    measure(1'b1, h);
    check("div3_high", h, 4);
    check("div3_fall_strb", fall_strb_o, 1);
    check("div3_no_rise_at_fall", rise_strb_o, 0);
    measure(1'b0, l);
    check("div3_low", l, 4);
    check("div3_rise_strb", rise_strb_o, 1);
    measure(1'b1, h);
    check("div3_high2", h, 4);
    req_i = 2'b00;
    wait_idle(n);
    check("div3_stop_low", n, 4);
    check("div3_stop_clk", sd_clk_o, 0);

    // Stall one cycle after a rise with div 4
    div_i = 8'd4;
    req_i = 2'b01;
    wait_rise(n);
    check("stall_first_rise", n, 6);
    tick();
    stall_i = 2'b10;
    #1;
    check("stall_en", en_o, 0);
    measure(1'b1, h);
    check("stall_high", h + 1, 5);
    check("stall_fall_strb", fall_strb_o, 1);
    r0 = rise_cnt;
    wait_idle(n);
    check("stall_low_to_idle", n, 5);
    check("stall_clk_low", sd_clk_o, 0);
    check("stall_no_rise", rise_cnt - r0, 0);
    stall_i = 2'b00;
    req_i = 2'b00;
    tick();

    // Divider change 1 -> 5 during a high phase
    div_i = 8'd1;
    req_i = 2'b01;
    wait_rise(n);
    check("dchg_first_rise", n, 3);
    div_i = 8'd5;
    measure(1'b1, h);
    check("dchg_high_old", h, 2);
    measure(1'b0, l);
    check("dchg_low_new", l, 6);
    measure(1'b1, h);
    check("dchg_high_new", h, 6);
    req_i = 2'b00;
    wait_idle(n);
    check("dchg_stop_low", n, 6);
    tick();

    // Restart on channel 1 with div 2, then reset while sd_clk is high
    div_i = 8'd2;
    req_i = 2'b10;
    #1;
    check("restart_en", en_o, 1);
    wait_rise(n);
    check("restart_first_rise", n, 4);
    check("restart_clk_high", sd_clk_o, 1);
    #2;
    rst_i = 1'b1;
    req_i = 2'b00;
    #1;
    check("rst_mid_high_clk", sd_clk_o, 0);
    check("rst_mid_high_rise", rise_strb_o, 0);
    check("rst_mid_high_fall", fall_strb_o, 0);
    check("rst_mid_high_running", running_o, 0);
    check("rst_mid_high_busy", burst_busy_o, 0);
    check("rst_mid_high_en", en_o, 0);
    #1;
    rst_i = 1'b0;
    tick();
    check("post_rst_fall", fall_strb_o, 0);
    check("post_rst_clk", sd_clk_o, 0);
    check("post_rst_running", running_o, 0);

`ifdef NEOSD_CLKGEN_BURST_EN
    // Burst of 74 at div 0 with every channel stalled
    div_i = 8'd0;
    stall_i = 2'b11;
    burst_len_i = 8'd74;
    burst_start_i = 1'b1;
    r0 = rise_cnt;
    tick();
    burst_start_i = 1'b0;
    #1;
    check("burst_busy_set", burst_busy_o, 1);
    check("burst_en_forced", en_o, 1);
    n = 0;
    while (burst_busy_o && n < 2000) begin
      burst_start_i = (n == 20);
      burst_len_i = (n == 20) ? 8'd5 : 8'd74;
      tick();
      n++;
    end
    burst_start_i = 1'b0;
    check("burst_end_fall", fall_strb_o, 1);
    check("burst_rises", rise_cnt - r0, 74);
    tick();
    check("burst_idle", running_o, 0);
    check("burst_no_extra_rise", rise_strb_o, 0);
    stall_i = 2'b00;
    burst_len_i = 8'd0;
    burst_start_i = 1'b1;
    tick();
    burst_start_i = 1'b0;
    check("burst_len0_ignored", burst_busy_o, 0);
`else
    // Without the burst feature the trigger has no effect
    burst_len_i = 8'd74;
    burst_start_i = 1'b1;
    tick();
    burst_start_i = 1'b0;
    check("noburst_busy", burst_busy_o, 0);
    check("noburst_en", en_o, 0);
    repeat (3) tick();
    check("noburst_running", running_o, 0);
`endif

    tick();
    check("strobe_exclusive", strb_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
